// File: rtl/fwd_hazard_unit.sv
// Forwarding / interlock control for a D/E/M/W pipeline, driven by a small
// scoreboard of per-stage destination, readiness and source-use metadata.
module fwd_hazard_unit #(
    parameter int unsigned AW      = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [1:0]    d_rs_tuse,
    input  logic [1:0]    d_rt_tuse,
    input  logic          d_wr,
    input  logic [AW-1:0] d_wa,
    input  logic [1:0]    d_rdy,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_read,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          fwd_rt_m,
    output logic          md_busy
);

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [AW-1:0] wa;
        logic [1:0]    rdy;
    } prod_t;

    // Later stages keep only the fields something downstream still reads.
    prod_t         r_e_p, r_m_p, r_w_p;
    logic [AW-1:0] r_e_rs, r_e_rt, r_m_rt;
    logic [1:0]    r_e_rs_tuse, r_e_rt_tuse, r_m_rt_tuse;
    logic          r_e_md_start, r_e_md_div;
    logic [CW-1:0] r_md_cnt;

    logic       w_rs_stall, w_rt_stall, w_md_stall, w_issue;
    logic [2:0] w_rs_d, w_rt_d;

    function automatic logic hit(input prod_t p, input logic [AW-1:0] src);
        return p.valid && p.wr && (p.wa == src) && (src != '0);
    endfunction

    function automatic logic [1:0] tnew(input logic [1:0] rdy, input logic [1:0] pos);
        return (rdy > pos) ? (rdy - pos) : 2'd0;
    endfunction

    // Returns {stall, select} for one D-stage source.
    function automatic logic [2:0] d_src(input logic [AW-1:0] src, input logic [1:0] tuse,
                                         input prod_t e, input prod_t m, input prod_t w);
        logic       found;
        logic [1:0] tn, code;
        found = 1'b1;
        tn    = 2'd0;
        code  = 2'd0;
        if (hit(e, src)) begin
            tn   = tnew(e.rdy, 2'd0);
            code = 2'd1;
        end else if (hit(m, src)) begin
            tn   = tnew(m.rdy, 2'd1);
            code = 2'd2;
        end else if (hit(w, src)) begin
            tn   = tnew(w.rdy, 2'd2);
            code = 2'd3;
        end else begin
            found = 1'b0;
        end
        return {found && (tuse != 2'd3) && (tn > tuse), (found && tn == 2'd0) ? code : 2'd0};
    endfunction

    function automatic logic [1:0] e_src(input logic valid, input logic [AW-1:0] src,
                                         input logic [1:0] tuse, input prod_t m, input prod_t w);
        if (!valid || tuse == 2'd3) return 2'd0;
        if (hit(m, src))            return 2'd1;
        if (hit(w, src))            return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        w_rs_d     = d_src(d_rs, d_rs_tuse, r_e_p, r_m_p, r_w_p);
        w_rt_d     = d_src(d_rt, d_rt_tuse, r_e_p, r_m_p, r_w_p);
        w_rs_stall = d_valid && w_rs_d[2];
        w_rt_stall = d_valid && w_rt_d[2];
        w_md_stall = d_valid && (d_md_read || d_md_start) &&
                     ((r_md_cnt != '0) || (r_e_p.valid && r_e_md_start));
        stall      = w_rs_stall || w_rt_stall || w_md_stall;
        w_issue    = d_valid && !stall;
        fwd_rs_d   = d_valid ? w_rs_d[1:0] : 2'd0;
        fwd_rt_d   = d_valid ? w_rt_d[1:0] : 2'd0;
        fwd_rs_e   = e_src(r_e_p.valid, r_e_rs, r_e_rs_tuse, r_m_p, r_w_p);
        fwd_rt_e   = e_src(r_e_p.valid, r_e_rt, r_e_rt_tuse, r_m_p, r_w_p);
        fwd_rt_m   = r_m_p.valid && (r_m_rt_tuse == 2'd2) && hit(r_w_p, r_m_rt);
        md_busy    = (r_md_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_p        <= '0;
            r_m_p        <= '0;
            r_w_p        <= '0;
            r_e_rs       <= '0;
            r_e_rt       <= '0;
            r_m_rt       <= '0;
            r_e_rs_tuse  <= '0;
            r_e_rt_tuse  <= '0;
            r_m_rt_tuse  <= '0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
        end else begin
            r_w_p        <= r_m_p;
            r_m_p        <= r_e_p;
            r_m_rt       <= r_e_rt;
            r_m_rt_tuse  <= r_e_rt_tuse;
            r_e_p        <= w_issue ? '{valid: 1'b1, wr: d_wr, wa: d_wa, rdy: d_rdy} : '0;
            r_e_rs       <= w_issue ? d_rs : '0;
            r_e_rt       <= w_issue ? d_rt : '0;
            r_e_rs_tuse  <= w_issue ? d_rs_tuse : 2'd3;
            r_e_rt_tuse  <= w_issue ? d_rt_tuse : 2'd3;
            r_e_md_start <= w_issue && d_md_start;
            r_e_md_div   <= w_issue && d_md_div;
        end
    end

    // Counter loads as the mult/div leaves E, so E occupancy and busy never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (r_e_p.valid && r_e_md_start) begin
            r_md_cnt <= r_e_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit; each scenario task checks its own outputs.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid, d_wr, d_md_start, d_md_div, d_md_read;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_rdy;
    logic       stall, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    int         n_vec = 0;
    int         n_err = 0;

    fwd_hazard_unit #(.AW(5), .MUL_LAT(4), .DIV_LAT(8), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wr(d_wr), .d_wa(d_wa),
        .d_rdy(d_rdy), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_read(d_md_read),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] rsu, input logic [1:0] rtu, input logic wr,
                         input logic [4:0] wa, input logic [1:0] rdy,
                         input logic mds, input logic mdd, input logic mdr);
        d_valid = v; d_rs = rs; d_rt = rt; d_rs_tuse = rsu; d_rt_tuse = rtu;
        d_wr = wr; d_wa = wa; d_rdy = rdy; d_md_start = mds; d_md_div = mdd; d_md_read = mdr;
        #1;
    endtask

    task automatic nop;
        drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic prod(input logic [4:0] wa, input logic [1:0] rdy);
        drive(1, 0, 0, 3, 3, 1, wa, rdy, 0, 0, 0);
    endtask

    task automatic flush;
        nop;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        nop;
        rst_n = 1'b0;
        drive(1, 3, 4, 0, 0, 1, 6, 1, 0, 0, 1);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL rst_fwd_rs_d got %0d exp 0", fwd_rs_d); end
        n_vec++; if (fwd_rt_d !== 2'd0) begin n_err++; $display("FAIL rst_fwd_rt_d got %0d exp 0", fwd_rt_d); end
        n_vec++; if (fwd_rs_e !== 2'd0) begin n_err++; $display("FAIL rst_fwd_rs_e got %0d exp 0", fwd_rs_e); end
        n_vec++; if (fwd_rt_e !== 2'd0) begin n_err++; $display("FAIL rst_fwd_rt_e got %0d exp 0", fwd_rt_e); end
        n_vec++; if (fwd_rt_m !== 1'b0) begin n_err++; $display("FAIL rst_fwd_rt_m got %0d exp 0", fwd_rt_m); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rst_md_busy got %0d exp 0", md_busy); end
        repeat (2) tick;
        rst_n = 1'b1;
        flush;
    endtask

    task automatic test_back_to_back;
        flush;
        prod(3, 1); tick;
        drive(1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_branch_stall got %0d exp 1", stall); end
        n_vec++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL b2b_branch_rs_d0 got %0d exp 0", fwd_rs_d); end
        tick;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_branch_release got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd2) begin n_err++; $display("FAIL b2b_branch_rs_d got %0d exp 2", fwd_rs_d); end
        n_vec++; if (fwd_rt_d !== 2'd0) begin n_err++; $display("FAIL b2b_branch_rt_d got %0d exp 0", fwd_rt_d); end
        flush;
        prod(3, 1); tick;
        drive(1, 3, 0, 1, 1, 1, 6, 1, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_alu_stall got %0d exp 0", stall); end
        tick; nop;
        n_vec++; if (fwd_rs_e !== 2'd1) begin n_err++; $display("FAIL b2b_alu_rs_e got %0d exp 1", fwd_rs_e); end
    endtask

    task automatic test_load_use;
        flush;
        prod(5, 2); tick;
        drive(0, 5, 0, 0, 1, 1, 8, 1, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL invalid_d_stall got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL invalid_d_rs_d got %0d exp 0", fwd_rs_d); end
        drive(1, 5, 0, 1, 1, 1, 8, 1, 0, 0, 0);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0d exp 1", stall); end
        tick;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_release got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL lu_rs_d got %0d exp 0", fwd_rs_d); end
        tick; nop;
        n_vec++; if (fwd_rs_e !== 2'd2) begin n_err++; $display("FAIL lu_rs_e got %0d exp 2", fwd_rs_e); end
        n_vec++; if (fwd_rt_e !== 2'd0) begin n_err++; $display("FAIL lu_rt_e_r0 got %0d exp 0", fwd_rt_e); end
    endtask

    task automatic test_store_data;
        flush;
        prod(7, 2); tick;
        drive(1, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_stall got %0d exp 0", stall); end
        tick; nop;
        n_vec++; if (fwd_rt_m !== 1'b0) begin n_err++; $display("FAIL st_rt_m_early got %0d exp 0", fwd_rt_m); end
        tick;
        n_vec++; if (fwd_rt_m !== 1'b1) begin n_err++; $display("FAIL st_rt_m got %0d exp 1", fwd_rt_m); end
    endtask

    task automatic test_link_r0;
        flush;
        prod(31, 0); tick;
        drive(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL jr_stall got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd1) begin n_err++; $display("FAIL jr_rs_d got %0d exp 1", fwd_rs_d); end
        flush;
        prod(0, 2); tick;
        drive(1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_stall got %0d exp 0", stall); end
        n_vec++; if (fwd_rs_d !== 2'd0) begin n_err++; $display("FAIL r0_rs_d got %0d exp 0", fwd_rs_d); end
        n_vec++; if (fwd_rt_d !== 2'd0) begin n_err++; $display("FAIL r0_rt_d got %0d exp 0", fwd_rt_d); end
        tick; nop;
        n_vec++; if (fwd_rs_e !== 2'd0) begin n_err++; $display("FAIL r0_rs_e got %0d exp 0", fwd_rs_e); end
        n_vec++; if (fwd_rt_e !== 2'd0) begin n_err++; $display("FAIL r0_rt_e got %0d exp 0", fwd_rt_e); end
        tick;
        n_vec++; if (fwd_rt_m !== 1'b0) begin n_err++; $display("FAIL r0_rt_m got %0d exp 0", fwd_rt_m); end
    endtask

    task automatic test_youngest;
        flush;
        prod(2, 1); tick;
        nop; tick; tick;
        drive(1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        n_vec++; if (fwd_rs_d !== 2'd3) begin n_err++; $display("FAIL yw_w_only got %0d exp 3", fwd_rs_d); end
        flush;
        prod(2, 1); tick;
        prod(2, 1); tick;
        nop; tick;
        drive(1, 2, 0, 1, 3, 1, 10, 1, 0, 0, 0);
        n_vec++; if (fwd_rs_d !== 2'd2) begin n_err++; $display("FAIL yw_rs_d got %0d exp 2", fwd_rs_d); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL yw_stall got %0d exp 0", stall); end
        tick; nop;
        n_vec++; if (fwd_rs_e !== 2'd2) begin n_err++; $display("FAIL yw_rs_e_w got %0d exp 2", fwd_rs_e); end
        flush;
        prod(2, 1); tick;
        prod(2, 1); tick;
        drive(1, 2, 0, 1, 3, 1, 10, 1, 0, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL yw_e_stall got %0d exp 0", stall); end
        tick; nop;
        n_vec++; if (fwd_rs_e !== 2'd1) begin n_err++; $display("FAIL yw_rs_e_m got %0d exp 1", fwd_rs_e); end
    endtask

    task automatic test_hilo;
        int n_st;
        int n_busy;
        flush;
        drive(1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0); tick;
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_in_e_busy got %0d exp 0", md_busy); end
        drive(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 1);
        n_st = 0; n_busy = 0;
        for (int i = 0; i < 20 && stall === 1'b1; i++) begin
            n_st++;
            if (md_busy === 1'b1) n_busy++;
            tick;
        end
        n_vec++; if (n_st != 9) begin n_err++; $display("FAIL mflo_stall_cycles got %0d exp 9", n_st); end
        n_vec++; if (n_busy != 8) begin n_err++; $display("FAIL div_busy_cycles got %0d exp 8", n_busy); end
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_done_busy got %0d exp 0", md_busy); end
        tick;
        drive(1, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0);
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult1_stall got %0d exp 0", stall); end
        tick;
        n_st = 0;
        for (int i = 0; i < 20 && stall === 1'b1; i++) begin
            n_st++;
            tick;
        end
        n_vec++; if (n_st != 5) begin n_err++; $display("FAIL mult2_stall_cycles got %0d exp 5", n_st); end
        tick; nop; tick;
        n_vec++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL mult2_busy got %0d exp 1", md_busy); end
        drive(1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 1);
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mflo_busy_stall got %0d exp 1", stall); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0d exp 0", md_busy); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall got %0d exp 0", stall); end
        tick;
        rst_n = 1'b1;
        nop;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load_use;
        test_store_data;
        test_link_r0;
        test_youngest;
        test_hilo;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
